pipe_fetch: RTL and testbench

//  Instruction-fetch stage: owns the PC and the synchronous instruction-memory port.

---
 rtl/pipe_fetch.sv | 128 ++++++++++++
 tb/tb_pipe_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction-fetch stage. Owns the PC and the synchronous
// instruction-memory port, and presents the fetched word with its PC and PC+4
// to ID. Redirects on a taken EX branch or an ID jump, and holds the fetched
// word across load-use stalls.
//
// Ports:
//   Clk, Reset_n          clock (rising edge) and synchronous active-low reset
//   Stall                 freeze PC and IF output (hazard unit)
//   IF_ID_Flush           kill the word currently presented on IF_Instruction
//   EX_PC_Branch/_target  taken branch resolved in EX and its target
//   ID_Jump/_target       jump decoded in ID and its target
//   Imem_addr, Imem_rd_en instruction-memory request (data returns next cycle)
//   Imem_rdata            instruction-memory read data
//   IF_Instruction, IF_PC, IF_PC_plus4, IF_Valid   fetched slot to ID
//   Misalign_err          one-cycle pulse: redirect target was not word aligned
module pipe_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        IF_ID_Flush,
  input  logic        EX_PC_Branch,
  input  logic [31:0] EX_Branch_target,
  input  logic        ID_Jump,
  input  logic [31:0] ID_Jump_target,
  output logic [31:0] Imem_addr,
  output logic        Imem_rd_en,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_plus4,
  output logic        IF_Valid,
  output logic        Misalign_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   inflight_pc;
  logic              inflight_valid;
  logic [XLEN-1:0]   hold_instr;
  logic              hold_valid;

  logic              redirect;
  logic              advance;
  logic [XLEN-1:0]   redir_target;
  logic [XLEN-1:0]   raw_instr;
  logic              kill;

  // Redirect selection: branch in EX is older than jump in ID, so it wins.
  always_comb begin
    redirect     = EX_PC_Branch | ID_Jump;
    redir_target = EX_PC_Branch ? EX_Branch_target : ID_Jump_target;
    advance      = redirect | ~Stall;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= BOOT;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (Stall && !redirect) state_nxt = HOLD;
      HOLD:    if (!Stall || redirect) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Output logic: killed slots become NOP; during HOLD the captured word is
  // replayed because memory data is undefined while the strobe is low.
  always_comb begin
    raw_instr      = hold_valid ? hold_instr : Imem_rdata;
    kill           = ~Reset_n | ~inflight_valid | IF_ID_Flush | (state == BOOT);
    IF_Instruction = kill ? NOP_INSTR : raw_instr;
    IF_Valid       = ~kill;
    IF_PC          = inflight_pc;
    IF_PC_plus4    = inflight_pc + XLEN'(4);
    Imem_addr      = fetch_pc;
    Imem_rd_en     = Reset_n & ~Stall;
  end

  // PC, in-flight slot tracking and misalignment pulse.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fetch_pc       <= RESET_PC;
      inflight_pc    <= RESET_PC;
      inflight_valid <= 1'b0;
      Misalign_err   <= 1'b0;
    end else begin
      Misalign_err <= redirect & (redir_target[1:0] != 2'b00);
      if (redirect)    fetch_pc <= {redir_target[XLEN-1:2], 2'b00};
      else if (!Stall) fetch_pc <= fetch_pc + XLEN'(4);
      if (advance) begin
        inflight_pc    <= fetch_pc;
        // Word fetched alongside a redirect is wrong-path.
        inflight_valid <= ~redirect;
      end
    end
  end

  // Stall capture: grab the presented word on entry to HOLD, drop it on exit.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hold_instr <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else if (state == RUN && state_nxt == HOLD) begin
      hold_instr <= Imem_rdata;
      hold_valid <= 1'b1;
    end else if (state == HOLD && state_nxt == RUN) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
module tb_pipe_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall;
  logic        IF_ID_Flush;
  logic        EX_PC_Branch;
  logic [31:0] EX_Branch_target;
  logic        ID_Jump;
  logic [31:0] ID_Jump_target;
  logic [31:0] Imem_addr;
  logic        Imem_rd_en;
  logic [31:0] Imem_rdata;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_plus4;
  logic        IF_Valid;
  logic        Misalign_err;

  int tests = 0;
  int fails = 0;

  pipe_fetch dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .Stall            (Stall),
    .IF_ID_Flush      (IF_ID_Flush),
    .EX_PC_Branch     (EX_PC_Branch),
    .EX_Branch_target (EX_Branch_target),
    .ID_Jump          (ID_Jump),
    .ID_Jump_target   (ID_Jump_target),
    .Imem_addr        (Imem_addr),
    .Imem_rd_en       (Imem_rd_en),
    .Imem_rdata       (Imem_rdata),
    .IF_Instruction   (IF_Instruction),
    .IF_PC            (IF_PC),
    .IF_PC_plus4      (IF_PC_plus4),
    .IF_Valid         (IF_Valid),
    .Misalign_err     (Misalign_err)
  );

  always #5 Clk = ~Clk;

  // Memory: word at byte address A holds A>>2; undefined when not strobed.
  always @(posedge Clk) begin
    if (Imem_rd_en) Imem_rdata <= Imem_addr >> 2;
    else            Imem_rdata <= 'x;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic valid);
    chk({tag, "_instr"}, IF_Instruction, instr);
    chk({tag, "_pc"}, IF_PC, pc);
    chk({tag, "_pc4"}, IF_PC_plus4, pc + 32'd4);
    chk({tag, "_valid"}, 32'(IF_Valid), 32'(valid));
  endtask

  initial begin
    Reset_n = 1'b0; Stall = 1'b0; IF_ID_Flush = 1'b0;
    EX_PC_Branch = 1'b0; EX_Branch_target = '0;
    ID_Jump = 1'b0; ID_Jump_target = '0;

    // Reset state
    tick(); tick();
    slot("rst", NOP, 32'h0, 1'b0);
    chk("rst_rden", 32'(Imem_rd_en), 32'h0);
    chk("rst_addr", Imem_addr, 32'h0);
    chk("rst_mis", 32'(Misalign_err), 32'h0);

    // 1. Sequential fetch
    Reset_n = 1'b1; #1;
    chk("boot_addr", Imem_addr, 32'h0);
    chk("boot_rden", 32'(Imem_rd_en), 32'h1);
    chk("boot_valid", 32'(IF_Valid), 32'h0);
    chk("boot_instr", IF_Instruction, NOP);
    tick(); chk("seq0_addr", Imem_addr, 32'h4); slot("seq0", 32'h0, 32'h0, 1'b1);
    tick(); chk("seq1_addr", Imem_addr, 32'h8); slot("seq1", 32'h1, 32'h4, 1'b1);
    tick(); chk("seq2_addr", Imem_addr, 32'hC); slot("seq2", 32'h2, 32'h8, 1'b1);

    // 2. Three-cycle stall replays word@0x8 while memory data is X
    Stall = 1'b1; #1;
    chk("stl_rden", 32'(Imem_rd_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_addr", Imem_addr, 32'hC);
      slot("stl", 32'h2, 32'h8, 1'b1);
    end
    Stall = 1'b0;
    tick(); chk("res_addr", Imem_addr, 32'h10); slot("res", 32'h3, 32'hC, 1'b1);

    // 3. Branch beats jump in the same cycle; one bubble
    EX_PC_Branch = 1'b1; EX_Branch_target = 32'h100;
    ID_Jump = 1'b1; ID_Jump_target = 32'h200;
    tick();
    EX_PC_Branch = 1'b0; ID_Jump = 1'b0;
    chk("br_addr", Imem_addr, 32'h100);
    chk("br_valid", 32'(IF_Valid), 32'h0);
    chk("br_instr", IF_Instruction, NOP);
    chk("br_mis", 32'(Misalign_err), 32'h0);
    tick(); chk("br1_addr", Imem_addr, 32'h104); slot("br1", 32'h40, 32'h100, 1'b1);

    // 4. Jump during HOLD overrides stall and drops the held word
    Stall = 1'b1;
    tick(); slot("hj_hold", 32'h40, 32'h100, 1'b1);
    ID_Jump = 1'b1; ID_Jump_target = 32'h40; #1;
    chk("hj_rden", 32'(Imem_rd_en), 32'h0);
    tick();
    ID_Jump = 1'b0; Stall = 1'b0;
    chk("hj_addr", Imem_addr, 32'h40);
    chk("hj_valid", 32'(IF_Valid), 32'h0);
    tick(); slot("hj1", 32'h10, 32'h40, 1'b1);

    // Flush kills the presented slot combinationally
    IF_ID_Flush = 1'b1; #1;
    chk("fl_valid", 32'(IF_Valid), 32'h0);
    chk("fl_instr", IF_Instruction, NOP);
    IF_ID_Flush = 1'b0; #1;
    chk("fl_off_valid", 32'(IF_Valid), 32'h1);

    // 5. Misaligned branch target: aligned fetch, one-cycle error pulse
    EX_PC_Branch = 1'b1; EX_Branch_target = 32'h102;
    tick();
    EX_PC_Branch = 1'b0;
    chk("mis_addr", Imem_addr, 32'h100);
    chk("mis_pulse", 32'(Misalign_err), 32'h1);
    tick();
    chk("mis_clear", 32'(Misalign_err), 32'h0);
    slot("mis1", 32'h40, 32'h100, 1'b1);

    // PC wrap at the top of the address space
    EX_PC_Branch = 1'b1; EX_Branch_target = 32'hFFFF_FFFC;
    tick();
    EX_PC_Branch = 1'b0;
    chk("wr_addr", Imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr1", Imem_addr, 32'h0);
    slot("wr1", 32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b1);
    tick(); slot("wr2", 32'h0, 32'h0, 1'b1);

    // 6. Reset during HOLD
    Stall = 1'b1;
    tick();
    Reset_n = 1'b0;
    tick();
    chk("rh_valid", 32'(IF_Valid), 32'h0);
    chk("rh_addr", Imem_addr, 32'h0);
    chk("rh_rden", 32'(Imem_rd_en), 32'h0);
    chk("rh_pc", IF_PC, 32'h0);
    Reset_n = 1'b1; Stall = 1'b0;
    tick(); slot("rh1", 32'h0, 32'h0, 1'b1);
    tick(); slot("rh2", 32'h1, 32'h4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
